fifo_umbrales: RTL and testbench

Synchronous FIFO that produces the occupancy-threshold and error status consumed by the flow-control state machine. It buffers words between the upstream source and the downstream consumer. Its high and low thresholds are programmed during the `init` phase. It drives the almost-full/almost-empty flags that feed the FSM's `UmbralMfs`/`UmbralVcs` inputs and a sticky error flag that feeds its error path.

---
 rtl/fifo_umbrales.sv | 122 ++++++++++++
 tb/tb_fifo_umbrales.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/fifo_umbrales.sv
// Synchronous FIFO with programmable almost-full/almost-empty thresholds
// and a sticky overflow/underflow error flag for the flow-control FSM.
module fifo_umbrales #(
    parameter int DATA_WIDTH = 6,
    parameter int ADDR_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  init,
    input  logic [ADDR_WIDTH:0]   umbral_alto_in,
    input  logic [ADDR_WIDTH:0]   umbral_bajo_in,
    input  logic                  wr_enable,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  rd_enable,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  fifo_full,
    output logic                  fifo_empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  error_out
);
    localparam int          CW       = ADDR_WIDTH + 1;
    localparam int unsigned DEPTH    = 2 ** ADDR_WIDTH;
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] ALTO_RST = CW'(DEPTH - 1);
    localparam logic [CW-1:0] BAJO_RST = CW'(1);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         cnt_q, cnt_d, alto_q, alto_d, bajo_q, bajo_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  valid_q, valid_d, err_q, err_d;
    logic                  full_q, empty_q, af_q, ae_q;
    logic                  rd_acc, wr_acc;

    always_comb begin
        rd_acc   = 1'b0;
        wr_acc   = 1'b0;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        alto_d   = alto_q;
        bajo_d   = bajo_q;
        dout_d   = dout_q;
        valid_d  = 1'b0;
        err_d    = err_q;
        if (init) begin
            alto_d   = (umbral_alto_in > DEPTH_C) ? DEPTH_C : umbral_alto_in;
            bajo_d   = (umbral_bajo_in > DEPTH_C) ? DEPTH_C : umbral_bajo_in;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
            err_d    = 1'b0;
        end else begin
            // A write into a full FIFO is only legal when a read frees a slot this cycle.
            rd_acc = rd_enable && (cnt_q != '0);
            wr_acc = wr_enable && ((cnt_q != DEPTH_C) || rd_acc);
            if (rd_acc) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
                dout_d   = mem_q[rd_ptr_q];
                valid_d  = 1'b1;
            end
            if (wr_acc) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (wr_acc && !rd_acc) begin
                cnt_d = cnt_q + 1'b1;
            end else if (rd_acc && !wr_acc) begin
                cnt_d = cnt_q - 1'b1;
            end
            err_d = err_q | (wr_enable & ~wr_acc) | (rd_enable & ~rd_acc);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && wr_acc) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

    // Status flags are computed from next-state values so they land on the same edge as count.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            alto_q   <= ALTO_RST;
            bajo_q   <= BAJO_RST;
            dout_q   <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            af_q     <= 1'b0;
            ae_q     <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            alto_q   <= alto_d;
            bajo_q   <= bajo_d;
            dout_q   <= dout_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
            full_q   <= (cnt_d == DEPTH_C);
            empty_q  <= (cnt_d == '0);
            af_q     <= (cnt_d >= alto_d);
            ae_q     <= (cnt_d <= bajo_d);
        end
    end

    assign data_out     = dout_q;
    assign valid_out    = valid_q;
    assign count        = cnt_q;
    assign fifo_full    = full_q;
    assign fifo_empty   = empty_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;
    assign error_out    = err_q;
endmodule

// File: tb/tb_fifo_umbrales.sv
// Directed table-driven bench for fifo_umbrales (DEPTH=4, 6-bit data),
// with a hand-written sequence for init held over several cycles.
module tb_fifo_umbrales;
    logic       clk = 1'b0;
    logic       reset, init, wr_enable, rd_enable;
    logic [2:0] umbral_alto_in, umbral_bajo_in;
    logic [5:0] data_in, data_out;
    logic       valid_out, fifo_full, fifo_empty, almost_full, almost_empty, error_out;
    logic [2:0] count;

    int checks   = 0;
    int failures = 0;

    fifo_umbrales #(.DATA_WIDTH(6), .ADDR_WIDTH(2)) dut (
        .clk(clk), .reset(reset), .init(init),
        .umbral_alto_in(umbral_alto_in), .umbral_bajo_in(umbral_bajo_in),
        .wr_enable(wr_enable), .data_in(data_in), .rd_enable(rd_enable),
        .data_out(data_out), .valid_out(valid_out), .count(count),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty),
        .almost_full(almost_full), .almost_empty(almost_empty),
        .error_out(error_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst, ini, wr, rd;
        logic [2:0] ua, ub;
        logic [5:0] din;
        logic [2:0] cnt;
        logic       full, empty, af, ae, err, vld;
        logic [5:0] dout;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input int rst, input int ini, input int ua, input int ub,
                       input int wr, input int din, input int rd,
                       input int cnt, input int full, input int empty, input int af,
                       input int ae, input int err, input int vld, input int dout);
        vec_t v;
        v.rst = 1'(rst); v.ini = 1'(ini); v.ua = 3'(ua); v.ub = 3'(ub);
        v.wr = 1'(wr); v.din = 6'(din); v.rd = 1'(rd);
        v.cnt = 3'(cnt); v.full = 1'(full); v.empty = 1'(empty); v.af = 1'(af);
        v.ae = 1'(ae); v.err = 1'(err); v.vld = 1'(vld); v.dout = 6'(dout);
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", name, got, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic ini, input logic [2:0] ua,
                         input logic [2:0] ub, input logic wr, input logic [5:0] din,
                         input logic rd);
        reset = rst; init = ini; umbral_alto_in = ua; umbral_bajo_in = ub;
        wr_enable = wr; data_in = din; rd_enable = rd;
        @(posedge clk);
        #1;
    endtask

    logic [14:0] got_p, exp_p;

    initial begin
        reset = 1'b1; init = 1'b0; umbral_alto_in = '0; umbral_bajo_in = '0;
        wr_enable = 1'b0; data_in = '0; rd_enable = 1'b0;

        //   rst ini ua ub wr din  rd | cnt fu em af ae er vl dout
        add(1, 0, 0, 0, 0, 'h00, 0,   0, 0, 1, 0, 1, 0, 0, 'h00); // 0 reset
        add(0, 1, 3, 1, 0, 'h00, 0,   0, 0, 1, 0, 1, 0, 0, 'h00); // 1 init 3/1
        add(0, 0, 0, 0, 1, 'h11, 0,   1, 0, 0, 0, 1, 0, 0, 'h00);
        add(0, 0, 0, 0, 1, 'h22, 0,   2, 0, 0, 0, 0, 0, 0, 'h00);
        add(0, 0, 0, 0, 1, 'h33, 0,   3, 0, 0, 1, 0, 0, 0, 'h00);
        add(0, 0, 0, 0, 1, 'h2A, 0,   4, 1, 0, 1, 0, 0, 0, 'h00); // 5 full
        add(0, 0, 0, 0, 0, 'h00, 1,   3, 0, 0, 1, 0, 0, 1, 'h11);
        add(0, 0, 0, 0, 0, 'h00, 1,   2, 0, 0, 0, 0, 0, 1, 'h22);
        add(0, 0, 0, 0, 0, 'h00, 1,   1, 0, 0, 0, 1, 0, 1, 'h33);
        add(0, 0, 0, 0, 0, 'h00, 1,   0, 0, 1, 0, 1, 0, 1, 'h2A);
        add(0, 0, 0, 0, 0, 'h00, 0,   0, 0, 1, 0, 1, 0, 0, 'h2A); // 10 hold
        add(0, 0, 0, 0, 1, 'h01, 0,   1, 0, 0, 0, 1, 0, 0, 'h2A);
        add(0, 0, 0, 0, 1, 'h02, 0,   2, 0, 0, 0, 0, 0, 0, 'h2A);
        add(0, 0, 0, 0, 1, 'h03, 0,   3, 0, 0, 1, 0, 0, 0, 'h2A);
        add(0, 0, 0, 0, 1, 'h04, 0,   4, 1, 0, 1, 0, 0, 0, 'h2A);
        add(0, 0, 0, 0, 1, 'h3F, 0,   4, 1, 0, 1, 0, 1, 0, 'h2A); // 15 overflow
        add(0, 0, 0, 0, 0, 'h00, 1,   3, 0, 0, 1, 0, 1, 1, 'h01);
        add(0, 0, 0, 0, 0, 'h00, 1,   2, 0, 0, 0, 0, 1, 1, 'h02);
        add(0, 0, 0, 0, 0, 'h00, 1,   1, 0, 0, 0, 1, 1, 1, 'h03);
        add(0, 0, 0, 0, 0, 'h00, 1,   0, 0, 1, 0, 1, 1, 1, 'h04);
        add(0, 1, 3, 1, 0, 'h00, 0,   0, 0, 1, 0, 1, 0, 0, 'h04); // 20 init clears err
        add(0, 0, 0, 0, 1, 'h0A, 0,   1, 0, 0, 0, 1, 0, 0, 'h04);
        add(0, 0, 0, 0, 1, 'h0B, 0,   2, 0, 0, 0, 0, 0, 0, 'h04);
        add(0, 0, 0, 0, 1, 'h0C, 0,   3, 0, 0, 1, 0, 0, 0, 'h04);
        add(0, 0, 0, 0, 1, 'h0D, 0,   4, 1, 0, 1, 0, 0, 0, 'h04);
        add(0, 0, 0, 0, 1, 'h10, 1,   4, 1, 0, 1, 0, 0, 1, 'h0A); // 25 full rd+wr
        add(0, 0, 0, 0, 1, 'h11, 1,   4, 1, 0, 1, 0, 0, 1, 'h0B);
        add(0, 0, 0, 0, 1, 'h12, 1,   4, 1, 0, 1, 0, 0, 1, 'h0C);
        add(0, 0, 0, 0, 0, 'h00, 1,   3, 0, 0, 1, 0, 0, 1, 'h0D);
        add(0, 0, 0, 0, 0, 'h00, 1,   2, 0, 0, 0, 0, 0, 1, 'h10);
        add(0, 0, 0, 0, 0, 'h00, 1,   1, 0, 0, 0, 1, 0, 1, 'h11);
        add(0, 0, 0, 0, 0, 'h00, 1,   0, 0, 1, 0, 1, 0, 1, 'h12);
        add(0, 0, 0, 0, 1, 'h05, 1,   1, 0, 0, 0, 1, 1, 0, 'h12); // 32 empty rd+wr
        add(0, 0, 0, 0, 0, 'h00, 1,   0, 0, 1, 0, 1, 1, 1, 'h05);
        add(0, 0, 0, 0, 1, 'h06, 0,   1, 0, 0, 0, 1, 1, 0, 'h05);
        add(0, 0, 0, 0, 1, 'h07, 0,   2, 0, 0, 0, 0, 1, 0, 'h05);
        add(0, 1, 7, 1, 1, 'h3E, 1,   0, 0, 1, 0, 1, 0, 0, 'h05); // 36 init alto=7 -> 4
        add(0, 0, 0, 0, 1, 'h08, 0,   1, 0, 0, 0, 1, 0, 0, 'h05);
        add(0, 0, 0, 0, 1, 'h09, 0,   2, 0, 0, 0, 0, 0, 0, 'h05);
        add(0, 0, 0, 0, 1, 'h0A, 0,   3, 0, 0, 0, 0, 0, 0, 'h05);
        add(0, 0, 0, 0, 1, 'h0B, 0,   4, 1, 0, 1, 0, 0, 0, 'h05);
        add(1, 1, 0, 0, 1, 'h0C, 1,   0, 0, 1, 0, 1, 0, 0, 'h00); // 41 reset mid-stream
        add(0, 0, 0, 0, 1, 'h01, 0,   1, 0, 0, 0, 1, 0, 0, 'h00);
        add(0, 0, 0, 0, 1, 'h02, 0,   2, 0, 0, 0, 0, 0, 0, 'h00);
        add(0, 0, 0, 0, 1, 'h03, 0,   3, 0, 0, 1, 0, 0, 0, 'h00);
        add(0, 1, 0, 7, 0, 'h00, 0,   0, 0, 1, 1, 1, 0, 0, 'h00); // 45 alto=0, bajo=7 -> 4
        add(0, 0, 0, 0, 1, 'h2C, 0,   1, 0, 0, 1, 1, 0, 0, 'h00);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].ini, vecs[i].ua, vecs[i].ub,
                  vecs[i].wr, vecs[i].din, vecs[i].rd);
            got_p = {count, fifo_full, fifo_empty, almost_full, almost_empty,
                     error_out, valid_out, data_out};
            exp_p = {vecs[i].cnt, vecs[i].full, vecs[i].empty, vecs[i].af, vecs[i].ae,
                     vecs[i].err, vecs[i].vld, vecs[i].dout};
            checks++;
            if (got_p !== exp_p) begin
                failures++;
                $display("FAIL vec%0d: got cnt=%0d fu=%b em=%b af=%b ae=%b err=%b vld=%b dout=%h ; expected cnt=%0d fu=%b em=%b af=%b ae=%b err=%b vld=%b dout=%h",
                         i, count, fifo_full, fifo_empty, almost_full, almost_empty,
                         error_out, valid_out, data_out,
                         vecs[i].cnt, vecs[i].full, vecs[i].empty, vecs[i].af,
                         vecs[i].ae, vecs[i].err, vecs[i].vld, vecs[i].dout);
            end
        end

        // init held two cycles: thresholds follow the inputs every cycle
        drive(1'b0, 1'b1, 3'd0, 3'd1, 1'b0, 6'h00, 1'b0);
        chk("hold_init_af_alto0", {29'd0, almost_full, count}, {29'd0, 1'b1, 3'd0});
        drive(1'b0, 1'b1, 3'd2, 3'd1, 1'b1, 6'h3A, 1'b0);
        chk("hold_init_af_alto2", {29'd0, almost_full, count}, {29'd0, 1'b0, 3'd0});
        drive(1'b0, 1'b0, 3'd0, 3'd0, 1'b1, 6'h15, 1'b0);
        chk("alto2_cnt1", {28'd0, almost_full, almost_empty, count}, {28'd0, 1'b0, 1'b1, 3'd1});
        drive(1'b0, 1'b0, 3'd0, 3'd0, 1'b1, 6'h16, 1'b0);
        chk("alto2_cnt2", {28'd0, almost_full, almost_empty, count}, {28'd0, 1'b1, 1'b0, 3'd2});
        drive(1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 6'h00, 1'b1);
        chk("read_first", {25'd0, valid_out, data_out}, {25'd0, 1'b1, 6'h15});
        drive(1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 6'h00, 1'b0);
        chk("valid_pulse_hold", {25'd0, valid_out, data_out}, {25'd0, 1'b0, 6'h15});
        chk("no_error", {31'd0, error_out}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
